spi_pwm_host: RTL and testbench

SPI initiator (host) that drives the 7-channel SPI PWM driver's serial port from an on-chip command interface. Accepts one write-level or read-level command at a time and issues the 2-byte SPI frame on sclk/cs/mosi. Returns the byte captured on miso. Sits between a controller (sequencer, UART bridge, test logic) and the pins wired to the PWM driver.

---
 rtl/spi_pwm_host.sv | 188 ++++++++++++++++++
 tb/tb_spi_pwm_host.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_host.sv
// rtl/spi_pwm_host.sv - SPI mode-0 host issuing 16-bit level frames to the PWM driver
//
// Accepts one command at a time and shifts a 16-bit frame out MSB first:
// byte1 = {write, 4'b0000, addr}, byte2 = data (writes) or 8'h00 (reads).
// The byte clocked in on miso during byte2 (LSB first) is returned on rsp_data.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only while idle)
//   cmd_write/cmd_addr/cmd_data command fields, latched on accept
//   rsp_valid/rsp_data         one-cycle completion pulse, captured byte (held)
//   sclk/cs/mosi/miso          SPI pins (sclk idle low, cs active low)
module spi_pwm_host #(
    parameter int HALF_PERIOD = 4,
    parameter int CS_GAP      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [2:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic        high_q, high_d;
    logic [15:0] shreg_q, shreg_d;
    logic [7:0]  rx_q, rx_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        sclk_q, sclk_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        high_d      = high_q;
        shreg_d     = shreg_q;
        rx_d        = rx_q;
        sync1_d     = miso;
        sync2_d     = sync1_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        sclk_d      = sclk_q;
        cs_d        = cs_q;
        mosi_d      = mosi_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d     = S_LOAD;
                    cmd_ready_d = 1'b0;
                    // Reads send an all-zero dummy so the device never arms a write.
                    shreg_d     = {cmd_write, 4'b0000, cmd_addr,
                                   cmd_write ? cmd_data : 8'h00};
                end
            end
            S_LOAD: begin
                // One cycle between accept and cs falling; bit 0 is presented with cs.
                state_d = S_SHIFT;
                cs_d    = 1'b0;
                sclk_d  = 1'b0;
                mosi_d  = shreg_q[15];
                div_d   = 8'd0;
                bit_d   = 4'd0;
                high_d  = 1'b0;
            end
            S_SHIFT: begin
                if (div_q != HP_LAST) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    if (!high_q) begin
                        high_d = 1'b1;
                        sclk_d = 1'b1;
                    end else begin
                        high_d = 1'b0;
                        sclk_d = 1'b0;
                        // Last cycle of a byte2 high phase: take the synchronized miso bit.
                        if (bit_q[3]) begin
                            rx_d[bit_q[2:0]] = sync2_q;
                        end
                        if (bit_q == 4'd15) begin
                            state_d = S_HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            shreg_d = {shreg_q[14:0], 1'b0};
                            mosi_d  = shreg_q[14];
                        end
                    end
                end
            end
            S_HOLD: begin
                // Keep cs low a half period so the device sees the 16th falling edge selected.
                if (div_q != HP_LAST) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d       = 8'd0;
                    state_d     = S_GAP;
                    cs_d        = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                end
            end
            S_GAP: begin
                if (div_q != GAP_LAST) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d       = 8'd0;
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= 8'd0;
            bit_q       <= 4'd0;
            high_q      <= 1'b0;
            shreg_q     <= 16'h0000;
            rx_q        <= 8'h00;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            high_q      <= high_d;
            shreg_q     <= shreg_d;
            rx_q        <= rx_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign sclk      = sclk_q;
    assign cs        = cs_q;
    assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_pwm_host.sv
// tb/tb_spi_pwm_host.sv - self-checking bench for spi_pwm_host with a behavioural PWM device
module tb_spi_pwm_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  cmd_valid_w;
    logic [1:0]  cmd_write_w;
    logic [5:0]  cmd_addr_w;
    logic [15:0] cmd_data_w;
    wire  [1:0]  cmd_ready_w;
    wire  [1:0]  rsp_valid_w;
    wire  [1:0]  sclk_w;
    wire  [1:0]  cs_w;
    wire  [1:0]  mosi_w;
    wire  [15:0] rsp_data_w;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] ref_level [2][8] = '{default: 8'h00};
    int cs_rise_abs = 0;
    int cs_low_abs  = 0;

    // Instance 0: HALF_PERIOD 4 / CS_GAP 4.  Instance 1: HALF_PERIOD 2 / CS_GAP 1.
    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : u
            localparam int H = (g == 0) ? 4 : 2;
            localparam int G = (g == 0) ? 4 : 1;

            logic        dev_miso = 1'b0;
            logic [7:0]  level [8] = '{default: 8'h00};
            logic [15:0] sh = 16'h0000;
            logic [15:0] frame = 16'h0000;
            int          nbits = 0;
            int          nframes = 0;
            logic        is_rd = 1'b0;
            logic [2:0]  rd_addr = 3'd0;

            spi_pwm_host #(.HALF_PERIOD(H), .CS_GAP(G)) dut (
                .clk       (clk),
                .reset     (reset),
                .cmd_valid (cmd_valid_w[g]),
                .cmd_ready (cmd_ready_w[g]),
                .cmd_write (cmd_write_w[g]),
                .cmd_addr  (cmd_addr_w[g*3 +: 3]),
                .cmd_data  (cmd_data_w[g*8 +: 8]),
                .rsp_valid (rsp_valid_w[g]),
                .rsp_data  (rsp_data_w[g*8 +: 8]),
                .sclk      (sclk_w[g]),
                .cs        (cs_w[g]),
                .mosi      (mosi_w[g]),
                .miso      (dev_miso)
            );

            // Device: samples mosi on rising sclk, drives miso after falling sclk,
            // commits a write on the 16th falling edge while still selected.
            always @(posedge sclk_w[g] or negedge sclk_w[g] or posedge cs_w[g] or posedge reset) begin
                if (reset || cs_w[g]) begin
                    nbits    = 0;
                    dev_miso = 1'b0;
                end else if (sclk_w[g]) begin
                    sh = {sh[14:0], mosi_w[g]};
                    nbits++;
                end else begin
                    if (nbits == 8) begin
                        is_rd   = !sh[7];
                        rd_addr = sh[2:0];
                    end
                    if (nbits >= 8 && nbits < 16) begin
                        dev_miso = (is_rd && rd_addr != 3'd7) ? level[rd_addr][nbits-8] : 1'b0;
                    end else if (nbits == 16) begin
                        frame    = sh;
                        nframes++;
                        dev_miso = 1'b0;
                        if (sh[15] && sh[10:8] != 3'd7) level[sh[10:8]] = sh[7:0];
                    end
                end
            end
        end
    endgenerate

    function automatic int hp(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int gp(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [7:0] dev_level(input int i, input logic [2:0] a);
        return (i == 0) ? u[0].level[a] : u[1].level[a];
    endfunction

    function automatic logic [15:0] dev_frame(input int i);
        return (i == 0) ? u[0].frame : u[1].frame;
    endfunction

    function automatic int dev_frames(input int i);
        return (i == 0) ? u[0].nframes : u[1].nframes;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command (called at a negedge) and follow the frame to completion.
    task automatic run_cmd(input int i, input logic w, input logic [2:0] a,
                           input logic [7:0] d, input bit keep, output int acc);
        int h, gg, cyc, wait_n;
        int rsp_e, rsp_n, rdy_e, low_first, low_n, rise1, rises, frames0;
        logic prev_sclk, prev_cs;
        logic [7:0] rsp, exp_rsp;
        logic [15:0] exp_frame;
        h         = hp(i);
        gg        = gp(i);
        exp_rsp   = w ? 8'h00 : ((a == 3'd7) ? 8'h00 : ref_level[i][a]);
        exp_frame = {w, 4'b0000, a, w ? d : 8'h00};
        frames0   = dev_frames(i);
        cmd_write_w[i]          = w;
        cmd_addr_w[i*3 +: 3]    = a;
        cmd_data_w[i*8 +: 8]    = d;
        cmd_valid_w[i]          = 1'b1;
        wait_n = 0;
        while (!cmd_ready_w[i] && wait_n < 1000) begin
            @(negedge clk);
            wait_n++;
        end
        chk("accept_wait", 32'(wait_n < 1000), 32'd1);
        acc = edge_cnt + 1;
        rsp_e = -1; rsp_n = 0; rdy_e = -1; low_first = -1; low_n = 0;
        rise1 = -1; rises = 0; prev_sclk = 1'b0; prev_cs = 1'b1; rsp = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            cyc = edge_cnt - acc;
            if (!keep) cmd_valid_w[i] = 1'b0;
            if (!cs_w[i]) begin
                low_n++;
                if (low_first < 0) begin
                    low_first  = cyc;
                    cs_low_abs = edge_cnt;
                end
            end
            if (cs_w[i] && !prev_cs) cs_rise_abs = edge_cnt;
            if (sclk_w[i] && !prev_sclk) begin
                rises++;
                if (rise1 < 0) rise1 = cyc;
            end
            if (rsp_valid_w[i]) begin
                rsp_n++;
                if (rsp_e < 0) begin
                    rsp_e = cyc;
                    rsp   = rsp_data_w[i*8 +: 8];
                end
            end
            prev_sclk = sclk_w[i];
            prev_cs   = cs_w[i];
            if (cmd_ready_w[i]) begin
                rdy_e = cyc;
                break;
            end
        end
        chk("ready_edge",      32'(rdy_e),     32'(1 + 33*h + gg));
        chk("rsp_edge",        32'(rsp_e),     32'(1 + 33*h));
        chk("rsp_pulses",      32'(rsp_n),     32'd1);
        chk("rsp_data",        32'(rsp),       32'(exp_rsp));
        chk("rsp_data_held",   32'(rsp_data_w[i*8 +: 8]), 32'(exp_rsp));
        chk("cs_low_first",    32'(low_first), 32'd1);
        chk("cs_low_len",      32'(low_n),     32'(33*h));
        chk("sclk_first_rise", 32'(rise1),     32'(1 + h));
        chk("sclk_rises",      32'(rises),     32'd16);
        chk("mosi_frame",      32'(dev_frame(i)), 32'(exp_frame));
        chk("dev_frames",      32'(dev_frames(i)), 32'(frames0 + 1));
        if (w && a != 3'd7) begin
            ref_level[i][a] = d;
            chk("dev_level", 32'(dev_level(i, a)), 32'(d));
        end
    endtask

    initial begin
        int acc, acc1, acc2, r1, n, rises, frames0;
        logic prev;
        reset       = 1'b1;
        cmd_valid_w = 2'b00;
        cmd_write_w = 2'b00;
        cmd_addr_w  = 6'd0;
        cmd_data_w  = 16'h0000;
        #1;
        chk("reset_cs",        32'(cs_w),        32'h3);
        chk("reset_sclk",      32'(sclk_w),      32'h0);
        chk("reset_mosi",      32'(mosi_w),      32'h0);
        chk("reset_cmd_ready", 32'(cmd_ready_w), 32'h3);
        chk("reset_rsp_valid", 32'(rsp_valid_w), 32'h0);
        chk("reset_rsp_data",  32'(rsp_data_w),  32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Directed write / read sequence on the default-parameter instance.
        run_cmd(0, 1'b1, 3'd0, 8'hA5, 1'b0, acc);
        run_cmd(0, 1'b1, 3'd2, 8'h3C, 1'b0, acc);
        run_cmd(0, 1'b0, 3'd2, 8'h00, 1'b0, acc);
        run_cmd(0, 1'b0, 3'd7, 8'h00, 1'b0, acc);
        run_cmd(0, 1'b1, 3'd0, 8'hFF, 1'b0, acc);
        run_cmd(0, 1'b0, 3'd0, 8'h00, 1'b0, acc);

        // Back-to-back writes with cmd_valid held high; cs is high for the GAP
        // cycles plus the idle/accept cycle and the load cycle.
        run_cmd(0, 1'b1, 3'd1, 8'h10, 1'b1, acc1);
        r1 = cs_rise_abs;
        run_cmd(0, 1'b1, 3'd3, 8'h20, 1'b1, acc2);
        cmd_valid_w[0] = 1'b0;
        chk("b2b_accept_spacing", 32'(acc2 - acc1), 32'(33*4 + 4 + 2));
        chk("b2b_cs_high",        32'(cs_low_abs - r1), 32'(4 + 2));

        // Reset during the high phase of the fifth sclk period.
        cmd_write_w[0] = 1'b1;
        cmd_addr_w[2:0] = 3'd5;
        cmd_data_w[7:0] = 8'h77;
        cmd_valid_w[0] = 1'b1;
        @(negedge clk);
        cmd_valid_w[0] = 1'b0;
        rises = 0;
        prev  = 1'b0;
        for (int c = 0; c < 500 && rises < 5; c++) begin
            @(negedge clk);
            if (sclk_w[0] && !prev) rises++;
            prev = sclk_w[0];
        end
        chk("reset_reach_bit5", 32'(rises), 32'd5);
        frames0 = dev_frames(0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_cs",        32'(cs_w[0]),        32'd1);
        chk("abort_sclk",      32'(sclk_w[0]),      32'd0);
        chk("abort_mosi",      32'(mosi_w[0]),      32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready_w[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (rsp_valid_w[0]) n++;
        end
        chk("abort_no_rsp",   32'(n), 32'd0);
        chk("abort_frames",   32'(dev_frames(0)), 32'(frames0));
        chk("abort_no_level", 32'(dev_level(0, 3'd5)), 32'(ref_level[0][5]));
        run_cmd(0, 1'b1, 3'd0, 8'h01, 1'b0, acc);

        // Randomized commands on the default instance.
        for (int k = 0; k < 6; k++) begin
            run_cmd(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    8'($urandom_range(0, 255)), 1'b0, acc);
        end

        // Parameter corner instance.
        run_cmd(1, 1'b1, 3'd4, 8'($urandom_range(0, 255)), 1'b0, acc);
        run_cmd(1, 1'b0, 3'd4, 8'h00, 1'b0, acc);
        run_cmd(1, 1'b0, 3'd7, 8'h00, 1'b0, acc);
        for (int k = 0; k < 4; k++) begin
            run_cmd(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    8'($urandom_range(0, 255)), 1'b0, acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
